// File: rtl/gpu_video_pkg.sv
// Shared video/framebuffer definitions for the z-buffer writer and scanout.
package gpu_video_pkg;

  // 640x480@60 timing, in pixel ticks (horizontal) and lines (vertical)
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Framebuffer is column-major: addr = x*FB_HEIGHT + y
  localparam int FB_WIDTH      = 640;
  localparam int FB_HEIGHT     = 480;
  localparam int FB_COL_STRIDE = FB_HEIGHT;

  localparam int PIXEL_W   = 24;
  localparam int FB_ADDR_W = 20;
  localparam int COORD_W   = 10;

  typedef logic [PIXEL_W-1:0]   pixel_t;
  typedef logic [FB_ADDR_W-1:0] fb_addr_t;
  typedef logic [COORD_W-1:0]   coord_t;

  // Region of a scan axis: visible, front porch, sync pulse, back porch
  typedef enum logic [1:0] {
    REGION_ACTIVE,
    REGION_FP,
    REGION_SYNC,
    REGION_BP
  } region_e;

  function automatic region_e region_of(input int pos, input int act,
                                        input int fp, input int sync);
    if (pos < act)                  return REGION_ACTIVE;
    else if (pos < act + fp)        return REGION_FP;
    else if (pos < act + fp + sync) return REGION_SYNC;
    else                            return REGION_BP;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-tick divider, h/v scan counters and region decode of the current position.
module vga_timing_gen
  import gpu_video_pkg::*;
#(
  parameter int H_ACTIVE = gpu_video_pkg::H_ACTIVE,
  parameter int H_FP     = gpu_video_pkg::H_FP,
  parameter int H_SYNC   = gpu_video_pkg::H_SYNC,
  parameter int H_BP     = gpu_video_pkg::H_BP,
  parameter int V_ACTIVE = gpu_video_pkg::V_ACTIVE,
  parameter int V_FP     = gpu_video_pkg::V_FP,
  parameter int V_SYNC   = gpu_video_pkg::V_SYNC,
  parameter int V_BP     = gpu_video_pkg::V_BP,
  parameter int CLK_DIV  = 2   // must be >= 2 so the 1-clk memory read fits inside a tick
) (
  input  logic               clk,
  input  logic               reset,
  output logic               tick,
  output logic [COORD_W-1:0] h,
  output logic [COORD_W-1:0] v,
  output logic               line_end,
  output logic [COORD_W-1:0] v_next,
  output logic               active,
  output logic               hsync_n,
  output logic               vsync_n,
  output logic               vblank
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam coord_t H_LAST = COORD_W'(H_TOT - 1);
  localparam coord_t V_LAST = COORD_W'(V_TOT - 1);
  localparam coord_t ONE    = COORD_W'(1);

  logic [DIV_W-1:0] div_q, div_d;
  coord_t           h_q, h_d;
  coord_t           v_q, v_d;
  region_e          h_region, v_region;

  // Divider wraps every CLK_DIV clks; h/v step only on the tick
  always_comb begin
    tick     = (div_q == DIV_LAST) && !reset;
    line_end = (h_q == H_LAST);
    v_next   = (v_q == V_LAST) ? '0 : v_q + ONE;
    div_d    = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    h_d      = h_q;
    v_d      = v_q;
    if (tick) begin
      if (line_end) begin
        h_d = '0;
        v_d = v_next;
      end else begin
        h_d = h_q + ONE;
      end
    end
  end

  // Counter state; reset restarts the scan at (0,0) with a fresh divider phase
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end

  // Decode sync/visibility for the position currently being addressed
  always_comb begin
    h_region = region_of(int'(h_q), H_ACTIVE, H_FP, H_SYNC);
    v_region = region_of(int'(v_q), V_ACTIVE, V_FP, V_SYNC);
    h        = h_q;
    v        = v_q;
    active   = (h_region == REGION_ACTIVE) && (v_region == REGION_ACTIVE);
    hsync_n  = (h_region != REGION_SYNC);
    vsync_n  = (v_region != REGION_SYNC);
    vblank   = (v_region != REGION_ACTIVE);
  end

endmodule

// File: rtl/display_scanout.sv
// Framebuffer scanout: address generation plus a one-tick output register.
module display_scanout
  import gpu_video_pkg::*;
#(
  parameter int H_ACTIVE   = gpu_video_pkg::H_ACTIVE,
  parameter int H_FP       = gpu_video_pkg::H_FP,
  parameter int H_SYNC     = gpu_video_pkg::H_SYNC,
  parameter int H_BP       = gpu_video_pkg::H_BP,
  parameter int V_ACTIVE   = gpu_video_pkg::V_ACTIVE,
  parameter int V_FP       = gpu_video_pkg::V_FP,
  parameter int V_SYNC     = gpu_video_pkg::V_SYNC,
  parameter int V_BP       = gpu_video_pkg::V_BP,
  parameter int CLK_DIV    = 2,
  parameter int COL_STRIDE = gpu_video_pkg::FB_COL_STRIDE
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [FB_ADDR_W-1:0] fb_read_addr,
  input  logic [PIXEL_W-1:0]   fb_read_data,
  output logic [PIXEL_W-1:0]   pixel,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 de,
  output logic [COORD_W-1:0]   counterX,
  output logic [COORD_W-1:0]   counterY,
  output logic                 frame_start,
  output logic                 vblank
);

  localparam fb_addr_t STRIDE = FB_ADDR_W'(COL_STRIDE);

  logic   tick, line_end, active, hsync_n, vsync_n, vblank_cur;
  coord_t h, v, v_next;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CLK_DIV (CLK_DIV)
  ) u_timing (
    .clk     (clk),
    .reset   (reset),
    .tick    (tick),
    .h       (h),
    .v       (v),
    .line_end(line_end),
    .v_next  (v_next),
    .active  (active),
    .hsync_n (hsync_n),
    .vsync_n (vsync_n),
    .vblank  (vblank_cur)
  );

  fb_addr_t addr_q, addr_d;
  pixel_t   pixel_q, pixel_d;
  coord_t   counterx_q, counterx_d, countery_q, countery_d;
  logic     hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic     frame_start_q, frame_start_d, vblank_q, vblank_d;

  // Running h*stride+v: step by one column while visible, reload at line end
  always_comb begin
    addr_d = addr_q;
    if (tick) begin
      if (line_end)
        addr_d = FB_ADDR_W'(v_next);
      else if (int'(h) < H_ACTIVE - 1)
        addr_d = addr_q + STRIDE;
    end
    fb_read_addr = active ? addr_q : '0;
  end

  // Capture the addressed position on the tick; frame_start only lives one clk
  always_comb begin
    pixel_d       = pixel_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    de_d          = de_q;
    counterx_d    = counterx_q;
    countery_d    = countery_q;
    vblank_d      = vblank_q;
    frame_start_d = 1'b0;
    if (tick) begin
      pixel_d       = active ? fb_read_data : '0;
      hsync_d       = hsync_n;
      vsync_d       = vsync_n;
      de_d          = active;
      counterx_d    = h;
      countery_d    = v;
      vblank_d      = vblank_cur;
      frame_start_d = (h == '0) && (v == '0);
    end
  end

  // Address and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q        <= '0;
      pixel_q       <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      de_q          <= 1'b0;
      counterx_q    <= '0;
      countery_q    <= '0;
      frame_start_q <= 1'b0;
      vblank_q      <= 1'b0;
    end else begin
      addr_q        <= addr_d;
      pixel_q       <= pixel_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      counterx_q    <= counterx_d;
      countery_q    <= countery_d;
      frame_start_q <= frame_start_d;
      vblank_q      <= vblank_d;
    end
  end

  assign pixel       = pixel_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign counterX    = counterx_q;
  assign counterY    = countery_q;
  assign frame_start = frame_start_q;
  assign vblank      = vblank_q;

endmodule

// File: tb/tb_display_scanout.sv
// Bench for display_scanout: full-size timing (first lines), a reduced
// geometry for whole-frame behaviour and mid-frame reset, and a CLK_DIV=4 build.
module tb_display_scanout;

  typedef struct packed {
    logic [19:0] addr;
    logic [23:0] pixel;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [9:0]  cx;
    logic [9:0]  cy;
    logic        fs;
    logic        vb;
  } obs_t;

  typedef struct packed {
    int d;
    int ha; int hfp; int hs; int hbp;
    int va; int vfp; int vs; int vbp;
    int stride;
  } geom_t;

  localparam geom_t GA = '{d:2, ha:640, hfp:16, hs:96, hbp:48, va:480, vfp:10, vs:2, vbp:33, stride:480};
  localparam geom_t GB = '{d:2, ha:12, hfp:3, hs:5, hbp:4, va:6, vfp:2, vs:2, vbp:3, stride:480};
  localparam geom_t GC = '{d:4, ha:12, hfp:3, hs:5, hbp:4, va:6, vfp:2, vs:2, vbp:3, stride:480};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected outputs m clks after the last reset-high edge: tick k shows
  // scan position k-1 (raster order); the address shows position k.
  function automatic obs_t model(input geom_t g, input int m, input logic [23:0] salt);
    obs_t e;
    int ht, vt, t, cur, prev, x, y, ax, ay;
    ht  = g.ha + g.hfp + g.hs + g.hbp;
    vt  = g.va + g.vfp + g.vs + g.vbp;
    t   = m / g.d;
    cur = t % (ht * vt);
    ax  = cur % ht;
    ay  = cur / ht;
    e       = '0;
    e.hsync = 1'b1;
    e.vsync = 1'b1;
    e.addr  = (ax < g.ha && ay < g.va) ? 20'(ax * g.stride + ay) : 20'd0;
    if (t > 0) begin
      prev    = (t - 1) % (ht * vt);
      x       = prev % ht;
      y       = prev / ht;
      e.de    = (x < g.ha) && (y < g.va);
      e.pixel = e.de ? (24'(x * g.stride + y) ^ salt) : 24'd0;
      e.hsync = !(x >= g.ha + g.hfp && x < g.ha + g.hfp + g.hs);
      e.vsync = !(y >= g.va + g.vfp && y < g.va + g.vfp + g.vs);
      e.cx    = 10'(x);
      e.cy    = 10'(y);
      e.fs    = (m % g.d == 0) && (x == 0) && (y == 0);
      e.vb    = (y >= g.va);
    end
    return e;
  endfunction

  // ---------------- instance A: full 640x480 timing ----------------
  logic        rst_a = 1'b1;
  logic [23:0] salt_a = 24'd0;
  logic [19:0] addr_a;
  logic [23:0] data_a, pix_a;
  logic        hs_a, vs_a, de_a, fs_a, vb_a;
  logic [9:0]  cx_a, cy_a;
  obs_t        obs_a;
  int          m_a = 0;

  display_scanout #(.CLK_DIV(2)) dut_a (
    .clk(clk), .reset(rst_a), .fb_read_addr(addr_a), .fb_read_data(data_a),
    .pixel(pix_a), .hsync(hs_a), .vsync(vs_a), .de(de_a),
    .counterX(cx_a), .counterY(cy_a), .frame_start(fs_a), .vblank(vb_a)
  );
  always @(posedge clk) data_a <= 24'(addr_a) ^ salt_a;
  always @(posedge clk) m_a <= rst_a ? 0 : m_a + 1;
  assign obs_a = {addr_a, pix_a, hs_a, vs_a, de_a, cx_a, cy_a, fs_a, vb_a};

  // ---------------- instance B: reduced geometry, CLK_DIV=2 ----------------
  logic        rst_b = 1'b1;
  logic [23:0] salt_b = 24'd0;
  logic [19:0] addr_b;
  logic [23:0] data_b, pix_b;
  logic        hs_b, vs_b, de_b, fs_b, vb_b;
  logic [9:0]  cx_b, cy_b;
  obs_t        obs_b;
  int          m_b = 0;

  display_scanout #(
    .H_ACTIVE(12), .H_FP(3), .H_SYNC(5), .H_BP(4),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .CLK_DIV(2), .COL_STRIDE(480)
  ) dut_b (
    .clk(clk), .reset(rst_b), .fb_read_addr(addr_b), .fb_read_data(data_b),
    .pixel(pix_b), .hsync(hs_b), .vsync(vs_b), .de(de_b),
    .counterX(cx_b), .counterY(cy_b), .frame_start(fs_b), .vblank(vb_b)
  );
  always @(posedge clk) data_b <= 24'(addr_b) ^ salt_b;
  always @(posedge clk) m_b <= rst_b ? 0 : m_b + 1;
  assign obs_b = {addr_b, pix_b, hs_b, vs_b, de_b, cx_b, cy_b, fs_b, vb_b};

  // ---------------- instance C: reduced geometry, CLK_DIV=4 ----------------
  logic        rst_c = 1'b1;
  logic [23:0] salt_c = 24'd0;
  logic [19:0] addr_c;
  logic [23:0] data_c, pix_c;
  logic        hs_c, vs_c, de_c, fs_c, vb_c;
  logic [9:0]  cx_c, cy_c;
  obs_t        obs_c;
  int          m_c = 0;

  display_scanout #(
    .H_ACTIVE(12), .H_FP(3), .H_SYNC(5), .H_BP(4),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .CLK_DIV(4), .COL_STRIDE(480)
  ) dut_c (
    .clk(clk), .reset(rst_c), .fb_read_addr(addr_c), .fb_read_data(data_c),
    .pixel(pix_c), .hsync(hs_c), .vsync(vs_c), .de(de_c),
    .counterX(cx_c), .counterY(cy_c), .frame_start(fs_c), .vblank(vb_c)
  );
  always @(posedge clk) data_c <= 24'(addr_c) ^ salt_c;
  always @(posedge clk) m_c <= rst_c ? 0 : m_c + 1;
  assign obs_c = {addr_c, pix_c, hs_c, vs_c, de_c, cx_c, cy_c, fs_c, vb_c};

  // ---------------- tests ----------------
  task automatic test_reset();
    obs_t e;
    rst_a  = 1'b1;
    salt_a = 24'd0;
    repeat (5) begin
      @(negedge clk);
      e = model(GA, m_a, salt_a);
      checks++;
      if (obs_a !== e) begin
        errors++;
        $display("FAIL reset_hold: got %h want %h", obs_a, e);
      end
    end
    rst_a = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      e = model(GA, m_a, salt_a);
      checks++;
      if (obs_a !== e) begin
        errors++;
        $display("FAIL reset_release m=%0d: got %h want %h", m_a, obs_a, e);
      end
      checks++;
      if (k == 2) begin
        if (!(fs_a === 1'b1 && cx_a === 10'd0 && cy_a === 10'd0 && de_a === 1'b1)) begin
          errors++;
          $display("FAIL first_tick: got fs=%b x=%0d y=%0d de=%b want fs=1 x=0 y=0 de=1",
                   fs_a, cx_a, cy_a, de_a);
        end
      end else if (fs_a !== 1'b0 || (k == 1 && de_a !== 1'b0)) begin
        errors++;
        $display("FAIL no_tick_yet k=%0d: got fs=%b de=%b want fs=0", k, fs_a, de_a);
      end
    end
    $display("test_reset done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_full_scan();
    obs_t e;
    int   low_cnt = 0;
    int   first_low = -1;
    bit   seen_3_0 = 0;
    bit   seen_0_1 = 0;
    while (m_a < 2 * 800 * 3 + 2) begin
      @(negedge clk);
      e = model(GA, m_a, salt_a);
      checks++;
      if (obs_a !== e) begin
        errors++;
        $display("FAIL full_scan m=%0d: got %h want %h", m_a, obs_a, e);
      end
      checks++;
      if (addr_a > 20'd307199) begin
        errors++;
        $display("FAIL addr_bound: got %0d want <= 307199", addr_a);
      end
      if (m_a > 0 && m_a % GA.d == 0) begin
        if (cy_a == 10'd0 && hs_a == 1'b0) begin
          low_cnt++;
          if (first_low < 0) first_low = int'(cx_a);
        end
        if (cx_a == 10'd3 && cy_a == 10'd0) begin
          seen_3_0 = 1;
          checks++;
          if (pix_a !== 24'd1440) begin
            errors++;
            $display("FAIL pixel_3_0: got %0d want 1440", pix_a);
          end
        end
        if (cx_a == 10'd0 && cy_a == 10'd1) begin
          seen_0_1 = 1;
          checks++;
          if (pix_a !== 24'd1) begin
            errors++;
            $display("FAIL pixel_0_1: got %0d want 1", pix_a);
          end
        end
        if (cx_a >= 10'd640) begin
          checks++;
          if (de_a !== 1'b0 || pix_a !== 24'd0) begin
            errors++;
            $display("FAIL hblank x=%0d: got de=%b pixel=%h want de=0 pixel=0", cx_a, de_a, pix_a);
          end
        end
      end
    end
    checks++;
    if (low_cnt != 96) begin
      errors++;
      $display("FAIL hsync_width: got %0d ticks want 96", low_cnt);
    end
    checks++;
    if (first_low != 656) begin
      errors++;
      $display("FAIL hsync_start: got x=%0d want 656", first_low);
    end
    checks++;
    if (!seen_3_0 || !seen_0_1) begin
      errors++;
      $display("FAIL probe_points: got seen=%b%b want 11", seen_3_0, seen_0_1);
    end
    $display("test_full_scan done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_small_frames();
    obs_t e;
    int   last_fs = -1;
    int   fs_cnt = 0;
    int   tick_no;
    bit   prev_vb = 0;
    bit   prev_vs = 1;
    bit   seen_last = 0;
    rst_b  = 1'b1;
    salt_b = 24'($urandom);
    repeat (3) @(negedge clk);
    rst_b = 1'b0;
    while (m_b < 2 * 3 * 312) begin
      @(negedge clk);
      e = model(GB, m_b, salt_b);
      checks++;
      if (obs_b !== e) begin
        errors++;
        $display("FAIL small_scan m=%0d: got %h want %h", m_b, obs_b, e);
      end
      if (m_b > 0 && m_b % GB.d == 0) begin
        tick_no = m_b / GB.d;
        if (fs_b) begin
          if (last_fs >= 0) begin
            checks++;
            if (tick_no - last_fs != 312) begin
              errors++;
              $display("FAIL frame_period: got %0d ticks want 312", tick_no - last_fs);
            end
          end
          last_fs = tick_no;
          fs_cnt++;
        end
        if (vb_b !== prev_vb) begin
          checks++;
          if (cy_b !== (vb_b ? 10'd6 : 10'd0)) begin
            errors++;
            $display("FAIL vblank_edge: got vblank=%b at y=%0d want y=%0d", vb_b, cy_b, vb_b ? 6 : 0);
          end
          prev_vb = vb_b;
        end
        if (vs_b !== prev_vs) begin
          checks++;
          if (cy_b !== (vs_b ? 10'd10 : 10'd8) || cx_b !== 10'd0) begin
            errors++;
            $display("FAIL vsync_edge: got vsync=%b at x=%0d y=%0d want x=0 y=%0d",
                     vs_b, cx_b, cy_b, vs_b ? 10 : 8);
          end
          prev_vs = vs_b;
        end
        if (cx_b == 10'd11 && cy_b == 10'd5) begin
          seen_last = 1;
          checks++;
          if (pix_b !== (24'd5285 ^ salt_b)) begin
            errors++;
            $display("FAIL last_pixel: got %h want %h", pix_b, 24'd5285 ^ salt_b);
          end
        end
      end
    end
    checks++;
    if (fs_cnt != 3 || !seen_last) begin
      errors++;
      $display("FAIL frame_count: got %0d pulses (last seen=%b) want 3", fs_cnt, seen_last);
    end
    $display("test_small_frames done: salt=%h checks=%0d errors=%0d", salt_b, checks, errors);
  endtask

  task automatic test_reset_midframe();
    obs_t e;
    int   wait_clks;
    for (int it = 0; it < 2; it++) begin
      wait_clks = int'($urandom_range(40, 600));
      repeat (wait_clks) begin
        @(negedge clk);
        e = model(GB, m_b, salt_b);
        checks++;
        if (obs_b !== e) begin
          errors++;
          $display("FAIL pre_reset m=%0d: got %h want %h", m_b, obs_b, e);
        end
      end
      rst_b = 1'b1;
      @(negedge clk);
      e = model(GB, m_b, salt_b);
      checks++;
      if (obs_b !== e) begin
        errors++;
        $display("FAIL midframe_reset: got %h want %h", obs_b, e);
      end
      rst_b = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (!(cx_b === 10'd0 && cy_b === 10'd0 && fs_b === 1'b1 && pix_b === salt_b)) begin
        errors++;
        $display("FAIL restart_tick: got x=%0d y=%0d fs=%b pixel=%h want 0 0 1 %h",
                 cx_b, cy_b, fs_b, pix_b, salt_b);
      end
      repeat (300) begin
        @(negedge clk);
        e = model(GB, m_b, salt_b);
        checks++;
        if (obs_b !== e) begin
          errors++;
          $display("FAIL post_reset m=%0d: got %h want %h", m_b, obs_b, e);
        end
      end
      $display("test_reset_midframe reset after %0d clks: checks=%0d errors=%0d", wait_clks, checks, errors);
    end
  endtask

  task automatic test_div4();
    obs_t       e;
    logic [9:0] prev_cx = 10'd0;
    int         run_len = 0;
    bit         run_started = 0;
    rst_c  = 1'b1;
    salt_c = 24'($urandom);
    repeat (2) @(negedge clk);
    rst_c = 1'b0;
    while (m_c < 4 * 2 * 312 + 1) begin
      @(negedge clk);
      e = model(GC, m_c, salt_c);
      checks++;
      if (obs_c !== e) begin
        errors++;
        $display("FAIL div4_scan m=%0d: got %h want %h", m_c, obs_c, e);
      end
      if (cx_c !== prev_cx) begin
        if (run_started) begin
          checks++;
          if (run_len != 4) begin
            errors++;
            $display("FAIL div4_hold: x=%0d held %0d clks want 4", prev_cx, run_len);
          end
        end
        run_started = 1;
        run_len = 1;
        prev_cx = cx_c;
      end else begin
        run_len++;
      end
      if (m_c > 0 && m_c % GC.d == 0 && de_c) begin
        checks++;
        if (pix_c !== (24'(int'(cx_c) * 480 + int'(cy_c)) ^ salt_c)) begin
          errors++;
          $display("FAIL div4_pixel x=%0d y=%0d: got %h want %h", cx_c, cy_c, pix_c,
                   24'(int'(cx_c) * 480 + int'(cy_c)) ^ salt_c);
        end
      end
    end
    $display("test_div4 done: salt=%h checks=%0d errors=%0d", salt_c, checks, errors);
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_small_frames();
    test_reset_midframe();
    test_div4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
